// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder, LSB-first operand shift registers, a carry
// flip-flop and an IDLE/ADD/DONE controller with a start/done handshake.

module fulladder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);
    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_carry_out;

    fulladder u_fa (
        .a         (a_sh[0]),
        .b         (b_sh[0]),
        .carry_in  (carry_q),
        .sum       (fa_sum),
        .carry_out (fa_carry_out)
    );

    // carry_out/overflow only update on the MSB edge so they keep the previous
    // operation's values while the next one is still being shifted through.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh    <= op_a;
                        b_sh    <= op_b;
                        carry_q <= carry_in;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    result  <= {fa_sum, result[WIDTH-1:1]};
                    carry_q <= fa_carry_out;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        carry_out <= fa_carry_out;
                        overflow  <= carry_q ^ fa_carry_out;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed and random additions
// against an arithmetic reference model, plus handshake and reset scenarios.

module tb_serial_adder_ctrl;
    localparam int W = 8;
    localparam int P = W + 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         carry_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    // Reference values of the most recently completed operation
    logic         prev_co = 1'b0;
    logic         prev_ov = 1'b0;

    // Observations gathered by run_op
    int           busy_cnt, busy_first, busy_last, done_cnt, done_at, done_in_busy;
    logic [W-1:0] res_at_done, res_after;
    logic         co_at_done, ov_at_done, co_pre, ov_pre;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin);
        logic [W:0] s;
        logic       ov;
        s  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {ov, s};
    endfunction

    // Drives one accepted start and records what the outputs did for W+3 cycles.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int mid_start);
        busy_cnt = 0; busy_first = 0; busy_last = 0;
        done_cnt = 0; done_at = 0; done_in_busy = 0;
        res_after = '0; co_pre = 1'b0; ov_pre = 1'b0;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; carry_in = cin;
        @(negedge clk);
        for (int i = 1; i <= W + 3; i++) begin
            if (busy) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = i;
                busy_last = i;
                if (done) done_in_busy++;
            end
            if (done) begin
                done_cnt++;
                done_at     = i;
                res_at_done = result;
                co_at_done  = carry_out;
                ov_at_done  = overflow;
            end
            if (i == W) begin
                co_pre = carry_out;
                ov_pre = overflow;
            end
            if (i == W + 2) res_after = result;
            start    = (mid_start != 0 && i == mid_start);
            op_a     = start ? '1 : W'($urandom);
            op_b     = start ? '1 : W'($urandom);
            carry_in = start ? 1'b1 : 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done, result, carry_out, overflow} !== '0) begin
                n_err++;
                $display("[TB] FAIL reset_idle cycle %0d: busy=%b done=%b result=%h co=%b ov=%b, expected all 0",
                         i, busy, done, result, carry_out, overflow);
            end
        end
        prev_co = 1'b0;
        prev_ov = 1'b0;
    endtask

    task automatic test_arith();
        logic [W-1:0] va[3] = '{8'h5A, 8'hFF, 8'h7F};
        logic [W-1:0] vb[3] = '{8'h33, 8'h01, 8'h00};
        logic         vc[3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] a, b;
        logic         c;
        logic [W+1:0] exp;
        for (int n = 0; n < 23; n++) begin
            if (n < 3) begin
                a = va[n]; b = vb[n]; c = vc[n];
            end else begin
                a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            end
            exp = ref_add(a, b, c);
            run_op(a, b, c, 0);
            n_cmp++;
            if (busy_cnt != W || busy_first != 1 || busy_last != W) begin
                n_err++;
                $display("[TB] FAIL busy_window op %0d: count=%0d first=%0d last=%0d, expected %0d cycles 1..%0d",
                         n, busy_cnt, busy_first, busy_last, W, W);
            end
            n_cmp++;
            if (done_cnt != 1 || done_at != W + 1 || done_in_busy != 0) begin
                n_err++;
                $display("[TB] FAIL done_pulse op %0d: count=%0d at=%0d overlap=%0d, expected 1 at %0d",
                         n, done_cnt, done_at, done_in_busy, W + 1);
            end
            n_cmp++;
            if ({ov_at_done, co_at_done, res_at_done} !== exp) begin
                n_err++;
                $display("[TB] FAIL sum op %0d (%h+%h+%b): ov=%b co=%b res=%h, expected ov=%b co=%b res=%h",
                         n, a, b, c, ov_at_done, co_at_done, res_at_done, exp[W+1], exp[W], exp[W-1:0]);
            end
            n_cmp++;
            if (co_pre !== prev_co || ov_pre !== prev_ov) begin
                n_err++;
                $display("[TB] FAIL flag_hold op %0d: co=%b ov=%b on last ADD cycle, expected previous co=%b ov=%b",
                         n, co_pre, ov_pre, prev_co, prev_ov);
            end
            n_cmp++;
            if (res_after !== exp[W-1:0]) begin
                n_err++;
                $display("[TB] FAIL result_hold op %0d: result=%h after done, expected %h",
                         n, res_after, exp[W-1:0]);
            end
            prev_co = exp[W];
            prev_ov = exp[W+1];
        end
    endtask

    task automatic test_ignore_start();
        run_op(8'h01, 8'h01, 1'b0, 3);
        n_cmp++;
        if (done_cnt != 1 || busy_cnt != W || res_at_done !== 8'h02 || co_at_done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL ignore_start: dones=%0d busy=%0d res=%h co=%b, expected 1 done, %0d busy, res=02 co=0",
                     done_cnt, busy_cnt, res_at_done, co_at_done, W);
        end
        prev_co = 1'b0;
        prev_ov = 1'b0;
    endtask

    task automatic test_reset_mid_add();
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        start = 1'b1; op_a = 8'h10; op_b = 8'h20; carry_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({busy, done, result, carry_out, overflow} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_mid_add: busy=%b done=%b result=%h co=%b ov=%b, expected all 0",
                     busy, done, result, carry_out, overflow);
        end
        for (int i = 0; i < W + 2; i++) begin
            if (done || busy) seen_done++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen_done != 0) begin
            n_err++;
            $display("[TB] FAIL reset_no_done: %0d busy/done cycles after reset, expected 0", seen_done);
        end
        prev_co = 1'b0;
        prev_ov = 1'b0;
        run_op(8'h10, 8'h20, 1'b0, 0);
        n_cmp++;
        if (done_cnt != 1 || res_at_done !== 8'h30 || co_at_done !== 1'b0 || ov_at_done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL after_reset_add: dones=%0d res=%h co=%b ov=%b, expected 1 done res=30 co=0 ov=0",
                     done_cnt, res_at_done, co_at_done, ov_at_done);
        end
    endtask

    // start stays high: the model expects a fixed W+2 cycle rhythm of ADD, DONE, IDLE.
    task automatic test_back_to_back();
        localparam int N = 4;
        logic [W-1:0] qa[N], qb[N];
        logic         qc[N];
        logic [W+1:0] exp;
        int           n, phase;
        for (int k = 0; k < N; k++) begin
            qa[k] = W'($urandom); qb[k] = W'($urandom); qc[k] = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b1; op_a = qa[0]; op_b = qb[0]; carry_in = qc[0];
        @(negedge clk);
        for (int t = 1; t < N * P; t++) begin
            n     = (t - 1) / P;
            phase = (t - 1) % P;
            n_cmp++;
            if (busy !== (phase < W) || done !== (phase == W)) begin
                n_err++;
                $display("[TB] FAIL b2b_handshake t=%0d: busy=%b done=%b, expected busy=%b done=%b",
                         t, busy, done, phase < W, phase == W);
            end
            if (phase == W) begin
                exp = ref_add(qa[n], qb[n], qc[n]);
                n_cmp++;
                if ({overflow, carry_out, result} !== exp) begin
                    n_err++;
                    $display("[TB] FAIL b2b_sum op %0d: ov=%b co=%b res=%h, expected ov=%b co=%b res=%h",
                             n, overflow, carry_out, result, exp[W+1], exp[W], exp[W-1:0]);
                end
                prev_co = exp[W];
                prev_ov = exp[W+1];
                if (n + 1 < N) begin
                    op_a = qa[n+1]; op_b = qb[n+1]; carry_in = qc[n+1];
                end else begin
                    start = 1'b0;
                end
            end else if (phase < W) begin
                op_a = W'($urandom); op_b = W'($urandom); carry_in = 1'($urandom);
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL b2b_stop: busy=%b done=%b after start dropped, expected 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_ignore_start();
        test_reset_mid_add();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder built around one `fulladder` instance, plus operand shift registers, a carry flip-flop and a control FSM.
- Sits directly upstream of `fulladder`: each cycle it feeds the adder one bit pair and the stored carry, then consumes the sum and carry_out.
- Area-minimal alternative to a ripple-carry chain for the structural ALU. Its outputs are the full sum, carry and signed overflow, delivered with a start/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- op_a  input  WIDTH  operand A; captured on the accepted start.
- op_b  input  WIDTH  operand B; captured on the accepted start.
- carry_in  input  1  initial carry; captured on the accepted start.
- busy  output  1  high while bits are being processed (ADD state).
- done  output  1  one-cycle pulse; result/carry_out/overflow are valid.
- result  output  WIDTH  sum, valid from done until the next accepted start.
- carry_out  output  1  carry out of the MSB, same validity as result.
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB), same validity as result.

Behaviour:
- One clock; reset is synchronous and active-high. Reset dominates all other inputs.
- Reset values: FSM = IDLE; busy = 0, done = 0, result = 0, carry_out = 0, overflow = 0; shift registers, carry flip-flop and bit counter cleared.
- Bit counter width is $clog2(WIDTH).

FSM states: IDLE, ADD, DONE.

IDLE:
- busy = 0, done = 0.
- If start = 1 at a rising edge:
  - a_sh <= op_a, b_sh <= op_b.
  - carry_q <= carry_in, cnt <= 0.
  - result, carry_out and overflow are left unchanged.
  - next state = ADD.
- Otherwise remain in IDLE; all outputs hold.

ADD:
- busy = 1.
- `fulladder` inputs: a = a_sh[0], b = b_sh[0], carry_in = carry_q.
- Each edge:
  - result <= {fa_sum, result[WIDTH-1:1]} (LSB-first, shifts in from the MSB).
  - carry_q <= fa_carry_out.
  - a_sh, b_sh shift right by 1.
  - cnt <= cnt + 1.
- When cnt == WIDTH-1 (last bit, the MSB):
  - carry_out <= fa_carry_out.
  - overflow <= carry_q XOR fa_carry_out.
  - next state = DONE.
- start is ignored in ADD; operands are not re-captured.

DONE:
- done = 1, busy = 0.
- Next state = IDLE unconditionally.
- start is ignored in DONE; it is accepted again from the following IDLE cycle.

Timing:
- Accepting edge at cycle k. ADD occupies cycles k+1 .. k+WIDTH. done is high during cycle k+WIDTH+1.
- Minimum start-to-start spacing is WIDTH+2 cycles.
- result is not valid while busy = 1, because it holds partially shifted bits.
- carry_out and overflow keep their previous values until the last ADD edge.

Boundary conditions:
- Reset asserted mid-ADD or in DONE: next edge returns to IDLE with all outputs cleared; no done pulse.
- start held high continuously: a new operation is accepted in each IDLE cycle, i.e. back-to-back every WIDTH+2 cycles.
- Operand inputs may change freely after the accepting edge.
- All arithmetic is modulo 2^WIDTH; the carry beyond the MSB appears only on carry_out.

Test Plan:
- Reset, then idle 5 cycles -> busy = 0, done = 0, result = 0x00, carry_out = 0, overflow = 0 throughout.
- WIDTH=8, op_a = 0x5A, op_b = 0x33, carry_in = 0, start pulse -> busy high for exactly 8 cycles; done pulses in the 9th cycle after the accepting edge; result = 0x8D, carry_out = 0, overflow = 1.
- op_a = 0xFF, op_b = 0x01, carry_in = 0 -> result = 0x00, carry_out = 1, overflow = 0.
- Next operation: op_a = 0x7F, op_b = 0x00, carry_in = 1 -> result = 0x80, carry_out = 0, overflow = 1. Outputs from the previous add must hold until the last ADD edge of this one.
- Start 0x01 + 0x01; pulse start again with 0xFF + 0xFF during ADD -> second request ignored; result = 0x02, carry_out = 0; exactly one done pulse.
- Start 0x10 + 0x20, assert reset for 1 cycle at the 4th ADD cycle -> returns to IDLE, all outputs 0, no done pulse. A subsequent 0x10 + 0x20 completes with result = 0x30.
